lane_serializer: RTL and testbench
==================================

Name: lane_serializer

Overview:
- Per-lane parallel-to-serial stage directly downstream of the PHY TX byte-striping block.
- Consumes one 8-bit lane byte (data_out_0 or data_out_1 plus its valid) and shifts it out one bit per clock. Instantiated once per lane.
- Idle symbol boundaries carry the COM symbol 0xBC; after reset, a training burst of COM symbols precedes any data so the RX deserializer can align.

Parameters:
- COM_COUNT, 4: number of COM symbols sent in INIT before data is accepted (range 1..255).
- COM_SYMBOL, 8'hBC: idle/alignment symbol value.

Ports:
- clk_8f  input  1  bit clock, 8x the lane byte rate; single clock domain.
- reset  input  1  synchronous, active-high reset.
- data_in  input  8  lane byte from the TX striping stage.
- valid_in  input  1  data_in holds a valid byte.
- ready_out  output  1  a byte is accepted this cycle if valid_in is also high.
- data_out  output  1  serial bit, registered.
- active_out  output  1  high once training has completed (state ACTIVE).
- com_out  output  1  high while the bits on data_out belong to a COM symbol.

Behaviour:
- Reset (sampled on the clk_8f edge while reset=1):
  - state=INIT, bit_cnt=0, com_cnt=0, cur_sym=COM_SYMBOL, sym_is_com=1.
  - data_out=0, active_out=0, com_out=0.
- Each non-reset edge:
  - data_out <= cur_sym[7-bit_cnt] (MSB first).
  - com_out <= sym_is_com.
  - bit_cnt <= bit_cnt+1 mod 8.
- Symbol boundary = edge at which bit_cnt==7. On that edge cur_sym/sym_is_com load the next symbol:
  - INIT: load COM_SYMBOL, com_cnt++. When com_cnt==COM_COUNT-1 at the boundary, go to ACTIVE.
  - ACTIVE: if valid_in, load data_in (sym_is_com=0), else load COM_SYMBOL (sym_is_com=1).
- ready_out = (state==ACTIVE) && (bit_cnt==7). It is combinational from registers only, with no dependence on valid_in.
- Handshake:
  - Transfer occurs when valid_in && ready_out.
  - valid_in outside a boundary is ignored, with no buffering. Upstream must hold data until ready_out.
- Latency: a byte accepted at edge E has its MSB on data_out after edge E+1 and its LSB after edge E+8.
- Output streams:
  - First bit after reset release appears after the first non-reset edge: bit 7 of COM.
  - After reset release: exactly COM_COUNT complete COM symbols, then data/COM symbols with no gaps.
- active_out registered: rises on the boundary edge that enters ACTIVE, i.e. the same cycle the first post-training symbol starts serialising.
- Data value 0xBC is transmitted with com_out=0 (no escaping); the distinction exists only in com_out.
- Reset mid-symbol: partial symbol abandoned, INIT restarts, the in-flight byte is lost, ready_out drops in that same cycle.
- State machine: INIT, ACTIVE only. ACTIVE persists until reset.

Optional Feature:
- Macro SER_LSB_FIRST_EN.
- Defined: data_out <= cur_sym[bit_cnt] (LSB first); COM_SYMBOL 0xBC then appears on the wire as 0,0,1,1,1,1,0,1. All timing is unchanged.
- Undefined: MSB first as above.

Decomposition:
- Shared package phy_pkg:
  - COM symbol constant 8'hBC.
  - State enum {INIT, ACTIVE}.
  - Bit-counter width constant (3).
  - Package is also used by the RX deserializer/aligner.
- No sub-module is needed; a single flat module is enough. The top-level TX wrapper instantiates two lane_serializers fed by data_out_0/valid_out0 and data_out_1/valid_out1.

Test Plan:
- Reset held 2 edges, then released with COM_COUNT=4, valid_in=0 -> data_out = 10111100 x4 with com_out=1; active_out rises at edge 32 after release; the stream continues with 10111100.
- After ACTIVE, drive data_in=8'hEE with valid_in held until the ready_out pulse -> next 8 bits 11101110, com_out=0; ready_out high exactly 1 cycle in 8.
- Back-to-back bytes 8'hFF, 8'h12, 8'h34, each presented at consecutive boundaries -> contiguous 24 bits 11111111 00010010 00110100 with no COM between them.
- valid_in pulsed high at bit_cnt=3 only -> byte ignored, COM 10111100 sent, ready_out never coincides with the pulse.
- Reset asserted at bit_cnt=4 of byte 8'hAA -> data_out=0 and ready_out=0 the next cycle; after release, 4 full COMs precede any data.
- With SER_LSB_FIRST_EN, byte 8'h01 -> bits 10000000; COM -> 00111101.

Source files
------------

// File: rtl/phy_pkg.sv
// phy_pkg: definitions shared by the PHY TX lane serializer and the RX
// deserializer/aligner.
//   PHY_COM_SYMBOL : idle/alignment COM symbol value (8'hBC)
//   phy_state_t    : serializer link state, INIT (training) or ACTIVE
//   BIT_CNT_W      : width of the bit-within-symbol counter
package phy_pkg;

    localparam logic [7:0] PHY_COM_SYMBOL = 8'hBC;
    localparam int         BIT_CNT_W      = 3;

    typedef enum logic {
        INIT   = 1'b0,
        ACTIVE = 1'b1
    } phy_state_t;

endpackage

// File: rtl/lane_serializer.sv
// lane_serializer: per-lane parallel-to-serial stage. After reset it sends
// COM_COUNT COM symbols for RX alignment, then serialises one byte per 8
// clocks, filling idle symbol slots with COM.
//
// Ports:
//   clk_8f     in   bit clock (8x lane byte rate)
//   reset      in   synchronous active-high reset
//   data_in    in   [7:0] lane byte from the striping stage
//   valid_in   in   data_in holds a valid byte
//   ready_out  out  byte accepted this cycle if valid_in is high
//   data_out   out  serial bit (registered)
//   active_out out  training complete
//   com_out    out  data_out belongs to a COM symbol
//
// Build option: define SER_LSB_FIRST_EN to shift symbols LSB first
// (default MSB first). Timing is identical in both builds.
module lane_serializer
    import phy_pkg::*;
#(
    parameter int unsigned COM_COUNT  = 4,
    parameter logic [7:0]  COM_SYMBOL = PHY_COM_SYMBOL
) (
    input  logic       clk_8f,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       data_out,
    output logic       active_out,
    output logic       com_out
);

    phy_state_t           state, state_nxt;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [BIT_CNT_W-1:0] bit_idx;
    logic [7:0]           com_cnt, com_cnt_nxt;
    logic [7:0]           cur_sym, sym_nxt;
    logic                 sym_is_com, com_nxt;
    logic                 boundary;

    assign boundary  = (bit_cnt == 3'd7);
    // Registers only: the upstream stage may wait on ready before asserting valid.
    assign ready_out = (state == ACTIVE) && boundary;

`ifdef SER_LSB_FIRST_EN
    assign bit_idx = bit_cnt;
`else
    assign bit_idx = 3'd7 - bit_cnt;
`endif

    // Next symbol selection; only takes effect on the symbol boundary.
    always_comb begin
        state_nxt   = state;
        sym_nxt     = cur_sym;
        com_nxt     = sym_is_com;
        com_cnt_nxt = com_cnt;
        if (boundary) begin
            case (state)
                INIT: begin
                    sym_nxt     = COM_SYMBOL;
                    com_nxt     = 1'b1;
                    com_cnt_nxt = com_cnt + 8'd1;
                    if (com_cnt == 8'(COM_COUNT - 1))
                        state_nxt = ACTIVE;
                end
                ACTIVE: begin
                    if (valid_in) begin
                        sym_nxt = data_in;
                        com_nxt = 1'b0;
                    end else begin
                        sym_nxt = COM_SYMBOL;
                        com_nxt = 1'b1;
                    end
                end
                default: state_nxt = INIT;
            endcase
        end
    end

    always_ff @(posedge clk_8f) begin
        if (reset) begin
            state <= INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk_8f) begin
        if (reset) begin
            bit_cnt    <= '0;
            com_cnt    <= '0;
            cur_sym    <= COM_SYMBOL;
            sym_is_com <= 1'b1;
            data_out   <= 1'b0;
            com_out    <= 1'b0;
            active_out <= 1'b0;
        end else begin
            data_out   <= cur_sym[bit_idx];
            com_out    <= sym_is_com;
            bit_cnt    <= bit_cnt + 3'd1;
            active_out <= (state_nxt == ACTIVE);
            if (boundary) begin
                cur_sym    <= sym_nxt;
                sym_is_com <= com_nxt;
                com_cnt    <= com_cnt_nxt;
            end
        end
    end

endmodule

// File: tb/tb_lane_serializer.sv
// tb_lane_serializer: randomized + directed bench for lane_serializer with a
// symbol-queue reference model checked every cycle.
module tb_lane_serializer;
    import phy_pkg::*;

    localparam int CC = 4;

    logic       clk_8f   = 1'b0;
    logic       reset    = 1'b1;
    logic       valid_in = 1'b0;
    logic [7:0] data_in  = 8'h00;
    logic       ready_out, data_out, active_out, com_out;

    lane_serializer #(.COM_COUNT(CC)) dut (
        .clk_8f    (clk_8f),
        .reset     (reset),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .data_out  (data_out),
        .active_out(active_out),
        .com_out   (com_out)
    );

    always #5 clk_8f = ~clk_8f;

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Order in which a byte appears on the wire, as an 8-bit MSB-first word.
    function automatic logic [7:0] wire_of(input logic [7:0] b);
        logic [7:0] r;
`ifdef SER_LSB_FIRST_EN
        for (int i = 0; i < 8; i++) r[7-i] = b[i];
`else
        r = b;
`endif
        return r;
    endfunction

    // Reference model: e = edges since reset; symbol k occupies edges
    // 8k+1..8k+8. Symbols 0..CC are COM; later ones are decided at the
    // boundary where the handshake is sampled.
    int         e = 0;
    bit         started = 0;
    logic [8:0] syms[$];   // {is_com, byte}

    always @(posedge clk_8f) begin
        if (reset) begin
            syms.delete();
            for (int k = 0; k <= CC; k++) syms.push_back({1'b1, PHY_COM_SYMBOL});
            e       <= 0;
            started <= 1'b1;
        end else if (started) begin
            if (e >= 8*CC && e % 8 == 7)
                syms.push_back(valid_in ? {1'b0, data_in} : {1'b1, PHY_COM_SYMBOL});
            e <= e + 1;
        end
    end

    logic logd[0:4095];
    logic logc[0:4095];
    logic loga[0:4095];

    always @(negedge clk_8f) begin
        if (started) begin
            logic       ed, ec, ea, er;
            logic [8:0] s;
            int         k, p;
            ed = 1'b0; ec = 1'b0; ea = 1'b0;
            er = (e >= 8*CC) && (e % 8 == 7);
            if (e > 0) begin
                k = (e - 1) / 8;
                p = (e - 1) % 8;
                if (k < syms.size()) s = syms[k];
                else begin
                    s = 9'h0;
                    chk("model_range", 0, 1);
                end
`ifdef SER_LSB_FIRST_EN
                ed = s[p];
`else
                ed = s[7-p];
`endif
                ec = s[8];
                ea = (e >= 8*CC);
            end
            chk("cyc_data",   data_out,   ed);
            chk("cyc_com",    com_out,    ec);
            chk("cyc_active", active_out, ea);
            chk("cyc_ready",  ready_out,  er);
            if (e < 4096) begin
                logd[e] = data_out;
                logc[e] = com_out;
                loga[e] = active_out;
            end
        end
    end

    function automatic logic [31:0] word(input int s, input int n);
        logic [31:0] w = 0;
        for (int i = 0; i < n; i++) w = {w[30:0], logd[s+i]};
        return w;
    endfunction

    function automatic logic com_all(input int s, input int n);
        logic r = 1'b1;
        for (int i = 0; i < n; i++) r = r & logc[s+i];
        return r;
    endfunction

    function automatic logic com_any(input int s, input int n);
        logic r = 1'b0;
        for (int i = 0; i < n; i++) r = r | logc[s+i];
        return r;
    endfunction

    task automatic wait_e(input int n);
        int g = 0;
        while (e < n && g < 400) begin
            @(negedge clk_8f);
            g++;
        end
        if (e < n) chk("wait_timeout", e, n);
        #1;
    endtask

    // Present b until the ready pulse; E is the accepting edge number.
    task automatic send_byte(input logic [7:0] b, output int E);
        int g = 0;
        valid_in = 1'b1;
        data_in  = b;
        while (!ready_out && g < 32) begin
            @(negedge clk_8f);
            g++;
        end
        if (!ready_out) chk("send_timeout", 0, 1);
        E = e + 1;
        @(negedge clk_8f);
        valid_in = 1'b0;
    endtask

    initial begin
        int E, E1, E2, E3, B, cnt, g;
        logic [31:0] com4;
        com4 = {4{wire_of(PHY_COM_SYMBOL)}};

        repeat (2) @(posedge clk_8f);
        @(negedge clk_8f);
        chk("rst_data",   data_out,   0);
        chk("rst_active", active_out, 0);
        chk("rst_com",    com_out,    0);
        chk("rst_ready",  ready_out,  0);
        reset = 1'b0;

        // Training burst, then idle COM
        wait_e(40);
        chk("train_bits",   word(1, 32), com4);
        chk("train_bits_lit", word(1, 8),
`ifdef SER_LSB_FIRST_EN
            32'h3D
`else
            32'hBC
`endif
        );
        chk("train_com",    com_all(1, 32), 1);
        chk("active_e31",   loga[31], 0);
        chk("active_e32",   loga[32], 1);
        chk("idle_sym",     word(33, 8), {24'h0, wire_of(PHY_COM_SYMBOL)});

        cnt = 0;
        repeat (64) begin
            @(negedge clk_8f);
            cnt += int'(ready_out);
        end
        chk("ready_duty", cnt, 8);

        send_byte(8'hEE, E);
        wait_e(E + 8);
        chk("byte_ee",   word(E + 1, 8), {24'h0, wire_of(8'hEE)});
        chk("byte_ee_c", com_any(E + 1, 8), 0);

        send_byte(8'h01, E);
        wait_e(E + 8);
        chk("byte_01", word(E + 1, 8),
`ifdef SER_LSB_FIRST_EN
            32'h80
`else
            32'h01
`endif
        );

        send_byte(8'hFF, E1);
        send_byte(8'h12, E2);
        send_byte(8'h34, E3);
        chk("b2b_gap1", E2 - E1, 8);
        chk("b2b_gap2", E3 - E2, 8);
        wait_e(E1 + 24);
        chk("b2b_bits", word(E1 + 1, 24),
            {8'h0, wire_of(8'hFF), wire_of(8'h12), wire_of(8'h34)});
        chk("b2b_com",  com_any(E1 + 1, 24), 0);

        // valid pulse away from the boundary is dropped
        g = 0;
        while (e % 8 != 3 && g < 16) begin
            @(negedge clk_8f);
            g++;
        end
        #1;
        B = (e / 8 + 1) * 8;
        valid_in = 1'b1;
        data_in  = 8'h55;
        chk("pulse_ready", ready_out, 0);
        @(negedge clk_8f);
        valid_in = 1'b0;
        wait_e(B + 8);
        chk("pulse_sym", word(B + 1, 8), {24'h0, wire_of(PHY_COM_SYMBOL)});
        chk("pulse_com", com_all(B + 1, 8), 1);

        // Reset in the middle of an in-flight byte
        send_byte(8'hAA, E);
        g = 0;
        while (e % 8 != 4 && g < 16) begin
            @(negedge clk_8f);
            g++;
        end
        #1;
        reset = 1'b1;
        @(negedge clk_8f);
        chk("mid_rst_data",  data_out,  0);
        chk("mid_rst_ready", ready_out, 0);
        chk("mid_rst_act",   active_out, 0);
        reset    = 1'b0;
        valid_in = 1'b1;
        data_in  = 8'h66;
        wait_e(48);
        valid_in = 1'b0;
        chk("retrain_bits", word(1, 32), com4);
        chk("retrain_com",  com_all(1, 32), 1);
        chk("retrain_idle", word(33, 8), {24'h0, wire_of(PHY_COM_SYMBOL)});
        chk("retrain_data", word(41, 8), {24'h0, wire_of(8'h66)});

        // Random traffic with occasional resets
        repeat (3000) begin
            @(negedge clk_8f);
            #1;
            valid_in = 1'($urandom_range(0, 1));
            data_in  = 8'($urandom);
            reset    = ($urandom_range(0, 299) == 0);
        end
        reset = 1'b0;
        @(negedge clk_8f);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
